// File: rtl/writeback_regfile.sv
// writeback_regfile: 16x16 register file with writeback commit, 2-bit busy
// scoreboard, zero flag, R15 redirect pulse, sticky halt and retire counter.
// Optional feature: define BYPASS_WRITEBACK_EN to forward a same-cycle
// writeback to the read ports and suppress the corresponding stall.
module writeback_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [15:0] ir_in,
  input  logic [15:0] result,
  input  logic        mark_valid,
  input  logic [3:0]  mark_reg,
  input  logic [3:0]  rd_addr_a,
  input  logic [3:0]  rd_addr_b,
  output logic [15:0] rd_data_a,
  output logic [15:0] rd_data_b,
  output logic        stall,
  output logic        z_flag,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic        halted,
  output logic [15:0] retire_count,
  output logic        sb_overflow
);

  localparam logic [4:0] OP_SYS = 5'b10011;
  localparam logic [4:0] OP_NOP = 5'b10100;
  localparam logic [4:0] OP_STR = 5'b01111;

  logic [15:0] regs [16];
  logic [1:0]  busy [16];

  logic [4:0] opcode;
  logic [1:0] cc;
  logic [3:0] dest;
  logic       commit;
  logic       is_sys;
  logic       is_nop;
  logic       is_pre;
  logic       writes;
  logic       byp_a;
  logic       byp_b;
  logic       unused_ir;

  assign opcode    = ir_in[15:11];
  assign cc        = ir_in[10:9];
  assign dest      = ir_in[7:4];
  assign unused_ir = ^{ir_in[8], ir_in[3:0]};

  // Decode the committing instruction
  always_comb begin
    is_sys = (opcode == OP_SYS);
    is_nop = (opcode == OP_NOP);
    is_pre = (opcode[4:3] == 2'b11);
    commit = valid_in && !halted;
    writes = commit && !is_sys && !is_nop && !is_pre && (opcode != OP_STR);
  end

  // Read ports with optional writeback forwarding and hazard stall
  always_comb begin
`ifdef BYPASS_WRITEBACK_EN
    byp_a = writes && (dest == rd_addr_a) && (busy[dest] == 2'd1);
    byp_b = writes && (dest == rd_addr_b) && (busy[dest] == 2'd1);
`else
    byp_a = 1'b0;
    byp_b = 1'b0;
`endif
    rd_data_a = byp_a ? result : regs[rd_addr_a];
    rd_data_b = byp_b ? result : regs[rd_addr_b];
    stall     = ((busy[rd_addr_a] != 2'd0) && !byp_a) ||
                ((busy[rd_addr_b] != 2'd0) && !byp_b);
  end

  // Register file write on writing commits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
    end else if (writes) begin
      regs[dest] <= result;
    end
  end

  // Commit status: zero flag, redirect pulse, halt, retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_flag         <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      halted         <= 1'b0;
      retire_count   <= '0;
    end else begin
      redirect_valid <= writes && (dest == 4'd15);
      if (writes && (dest == 4'd15)) redirect_pc <= result;
      if (commit) begin
        retire_count <= retire_count + 16'd1;
        if ((cc == 2'b01) && !is_nop && !is_pre) z_flag <= (result == 16'd0);
        if (is_sys) halted <= 1'b1;
      end
    end
  end

  // Scoreboard: per-register saturating busy count, sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 16; i++) busy[i] <= '0;
      sb_overflow <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (mark_valid && (mark_reg == 4'(i)) && !(writes && (dest == 4'(i)))) begin
          if (busy[i] == 2'd3) sb_overflow <= 1'b1;
          else                 busy[i] <= busy[i] + 2'd1;
        end else if (writes && (dest == 4'(i)) && !(mark_valid && (mark_reg == 4'(i)))) begin
          if (busy[i] != 2'd0) busy[i] <= busy[i] - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed vector table followed by
// randomized traffic against a behavioural model, with mid-cycle resets.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [15:0] ir_in;
  logic [15:0] result;
  logic        mark_valid;
  logic [3:0]  mark_reg;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        stall;
  logic        z_flag;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halted;
  logic [15:0] retire_count;
  logic        sb_overflow;

  int checks = 0;
  int errors = 0;

`ifdef BYPASS_WRITEBACK_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  writeback_regfile dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ir_in(ir_in), .result(result),
    .mark_valid(mark_valid), .mark_reg(mark_reg), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .stall(stall), .z_flag(z_flag),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted),
    .retire_count(retire_count), .sb_overflow(sb_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [1:0] cc, input logic [3:0] d);
    return {op, cc, 1'b0, d, 4'h0};
  endfunction

  // ---------------- behavioural reference model ----------------
  logic [15:0] m_regs [16];
  int          m_busy [16];
  bit          m_z, m_h, m_rv, m_ovf;
  logic [15:0] m_rpc, m_rc;

  function automatic bit m_writes(input logic v, input logic [15:0] ir);
    logic [4:0] op;
    op = ir[15:11];
    if (!v || m_h) return 1'b0;
    return !(op == 5'b10011 || op == 5'b10100 || op == 5'b01111 || op[4:3] == 2'b11);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin m_regs[i] = 16'h0; m_busy[i] = 0; end
    m_z = 0; m_h = 0; m_rv = 0; m_ovf = 0; m_rpc = 16'h0; m_rc = 16'h0;
  endtask

  // Expected read data and stall contribution of one port before the edge
  task automatic m_read(input logic [3:0] a, output logic [15:0] d, output bit st);
    bit byp;
    byp = BYP && m_writes(valid_in, ir_in) && ir_in[7:4] == a && m_busy[a] == 1;
    d   = byp ? result : m_regs[a];
    st  = (m_busy[a] != 0) && !byp;
  endtask

  // Apply the clock edge to the model using the current inputs
  task automatic m_edge();
    bit c, w;
    logic [4:0] op;
    logic [3:0] d;
    op = ir_in[15:11];
    d  = ir_in[7:4];
    c  = valid_in && !m_h;
    w  = m_writes(valid_in, ir_in);
    m_rv = w && d == 4'd15;
    if (m_rv) m_rpc = result;
    if (c) begin
      m_rc = m_rc + 16'd1;
      if (ir_in[10:9] == 2'b01 && op != 5'b10100 && op[4:3] != 2'b11) m_z = (result == 16'h0);
      if (op == 5'b10011) m_h = 1;
    end
    if (mark_valid && w && mark_reg == d) begin
      // simultaneous mark and retire cancel
    end else begin
      if (mark_valid) begin
        if (m_busy[mark_reg] == 3) m_ovf = 1;
        else m_busy[mark_reg]++;
      end
      if (w && m_busy[d] > 0) m_busy[d]--;
    end
    if (w) m_regs[d] = result;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic v; logic [15:0] ir; logic [15:0] res; logic mv; logic [3:0] mr; logic [3:0] ra;
    logic [15:0] e_rd; logic e_stall; logic e_z; logic e_rv; logic [15:0] e_rpc;
    logic e_h; logic [15:0] e_rc; logic e_ovf;
  } vec_t;

  vec_t tbl [17];

  task automatic idle_inputs();
    valid_in = 0; ir_in = 16'h0; result = 16'h0; mark_valid = 0; mark_reg = 4'h0;
    rd_addr_a = 4'h0; rd_addr_b = 4'h0;
  endtask

  task automatic mid_cycle_reset();
    @(negedge clk);
    idle_inputs();
    #2 reset = 1;
    #1;
    m_reset();
    chk("rst_retire", retire_count, 16'h0);
    chk("rst_halted", {15'h0, halted}, 16'h0);
    chk("rst_z", {15'h0, z_flag}, 16'h0);
    chk("rst_rv", {15'h0, redirect_valid}, 16'h0);
    chk("rst_rpc", redirect_pc, 16'h0);
    chk("rst_ovf", {15'h0, sb_overflow}, 16'h0);
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
      #0.1;
      chk("rst_rd_a", rd_data_a, 16'h0);
      chk("rst_stall", {15'h0, stall}, 16'h0);
    end
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    logic [15:0] ed;
    logic [15:0] eb;
    bit sa, sb;
    idle_inputs();
    reset = 1;
    m_reset();

    //          v  ir                     res      mv mr ra  e_rd                 st        z  rv rpc    h  rc  ovf
    tbl[0]  = '{0, 16'h0,                 16'h0,   1, 3, 3,  16'h0,               0,        0, 0, 16'h0, 0, 0, 0};
    tbl[1]  = '{1, mk(5'b00001,2'b00,3),  16'h1234,0, 0, 3,  BYP?16'h1234:16'h0,  !BYP,     0, 0, 16'h0, 0, 1, 0};
    tbl[2]  = '{0, 16'h0,                 16'h0,   0, 0, 3,  16'h1234,            0,        0, 0, 16'h0, 0, 1, 0};
    tbl[3]  = '{0, 16'h0,                 16'h0,   1, 5, 5,  16'h0,               0,        0, 0, 16'h0, 0, 1, 0};
    tbl[4]  = '{1, mk(5'b00001,2'b00,5),  16'h00AA,0, 0, 5,  BYP?16'h00AA:16'h0,  !BYP,     0, 0, 16'h0, 0, 2, 0};
    tbl[5]  = '{1, mk(5'b00010,2'b01,1),  16'h0,   0, 0, 5,  16'h00AA,            0,        1, 0, 16'h0, 0, 3, 0};
    tbl[6]  = '{1, mk(5'b00001,2'b01,1),  16'h1,   0, 0, 1,  16'h0,               0,        0, 0, 16'h0, 0, 4, 0};
    tbl[7]  = '{1, mk(5'b00010,2'b00,1),  16'h0,   0, 0, 1,  16'h1,               0,        0, 0, 16'h0, 0, 5, 0};
    tbl[8]  = '{1, mk(5'b00011,2'b00,15), 16'h0040,0, 0, 1,  16'h0,               0,        0, 1, 16'h40,0, 6, 0};
    tbl[9]  = '{0, 16'h0,                 16'h0,   0, 0, 15, 16'h0040,            0,        0, 0, 16'h0, 0, 6, 0};
    tbl[10] = '{0, 16'h0,                 16'h0,   1, 2, 2,  16'h0,               0,        0, 0, 16'h0, 0, 6, 0};
    tbl[11] = '{0, 16'h0,                 16'h0,   1, 2, 2,  16'h0,               1,        0, 0, 16'h0, 0, 6, 0};
    tbl[12] = '{0, 16'h0,                 16'h0,   1, 2, 2,  16'h0,               1,        0, 0, 16'h0, 0, 6, 0};
    tbl[13] = '{0, 16'h0,                 16'h0,   1, 2, 2,  16'h0,               1,        0, 0, 16'h0, 0, 6, 1};
    tbl[14] = '{1, mk(5'b10011,2'b00,0),  16'h0,   0, 0, 2,  16'h0,               1,        0, 0, 16'h0, 1, 7, 1};
    tbl[15] = '{1, mk(5'b00001,2'b00,2),  16'hBEEF,0, 0, 2,  16'h0,               1,        0, 0, 16'h0, 1, 7, 1};
    tbl[16] = '{0, 16'h0,                 16'h0,   0, 0, 2,  16'h0,               1,        0, 0, 16'h0, 1, 7, 1};

    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    chk("reset_retire", retire_count, 16'h0);
    chk("reset_flags", {12'h0, z_flag, redirect_valid, halted, sb_overflow}, 16'h0);
    chk("reset_stall", {15'h0, stall}, 16'h0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      valid_in = tbl[i].v; ir_in = tbl[i].ir; result = tbl[i].res;
      mark_valid = tbl[i].mv; mark_reg = tbl[i].mr; rd_addr_a = tbl[i].ra; rd_addr_b = 4'h0;
      #1;
      chk($sformatf("t%0d_rd", i), rd_data_a, tbl[i].e_rd);
      chk($sformatf("t%0d_stall", i), {15'h0, stall}, {15'h0, tbl[i].e_stall});
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_z", i), {15'h0, z_flag}, {15'h0, tbl[i].e_z});
      chk($sformatf("t%0d_rv", i), {15'h0, redirect_valid}, {15'h0, tbl[i].e_rv});
      if (tbl[i].e_rv) chk($sformatf("t%0d_rpc", i), redirect_pc, tbl[i].e_rpc);
      chk($sformatf("t%0d_halt", i), {15'h0, halted}, {15'h0, tbl[i].e_h});
      chk($sformatf("t%0d_rc", i), retire_count, tbl[i].e_rc);
      chk($sformatf("t%0d_ovf", i), {15'h0, sb_overflow}, {15'h0, tbl[i].e_ovf});
    end

    // Reset asserted between edges after several commits
    mid_cycle_reset();

    // Randomized traffic against the model, reset between blocks
    for (int blk = 0; blk < 4; blk++) begin
      for (int n = 0; n < 150; n++) begin
        int r;
        logic [4:0] op;
        @(negedge clk);
        r = $urandom_range(0, 99);
        if (r < 2)       op = 5'b10011;
        else if (r < 8)  op = 5'b10100;
        else if (r < 14) op = 5'b01111;
        else if (r < 22) op = {2'b11, 3'($urandom_range(0, 7))};
        else             op = 5'($urandom_range(0, 15));
        valid_in   = ($urandom_range(0, 99) < 70);
        ir_in      = {op, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
        result     = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
        mark_valid = ($urandom_range(0, 99) < 35);
        mark_reg   = 4'($urandom_range(0, 15));
        rd_addr_a  = ($urandom_range(0, 1) == 1) ? ir_in[7:4] : 4'($urandom_range(0, 15));
        rd_addr_b  = 4'($urandom_range(0, 15));
        #1;
        m_read(rd_addr_a, ed, sa);
        m_read(rd_addr_b, eb, sb);
        chk("rnd_rd_a", rd_data_a, ed);
        chk("rnd_rd_b", rd_data_b, eb);
        chk("rnd_stall", {15'h0, stall}, {15'h0, sa || sb});
        @(posedge clk);
        m_edge();
        #1;
        chk("rnd_z", {15'h0, z_flag}, {15'h0, m_z});
        chk("rnd_rv", {15'h0, redirect_valid}, {15'h0, m_rv});
        if (m_rv) chk("rnd_rpc", redirect_pc, m_rpc);
        chk("rnd_halt", {15'h0, halted}, {15'h0, m_h});
        chk("rnd_rc", retire_count, m_rc);
        chk("rnd_ovf", {15'h0, sb_overflow}, {15'h0, m_ovf});
      end
      // Sweep the whole register file through port a
      @(negedge clk);
      idle_inputs();
      for (int i = 0; i < 16; i++) begin
        rd_addr_a = 4'(i);
        #0.1;
        chk("sweep_rd", rd_data_a, m_regs[i]);
      end
      mid_cycle_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 valid_in  input  1  commit request from the ALU/memory stage this cycle.
REQ-004 ir_in  input  16  committing instruction: opcode [15:11], cc [10:9], dest [7:4].
REQ-005 result  input  16  value to write to dest.
REQ-006 mark_valid  input  1  decode stage issues an instruction that will write mark_reg.
REQ-007 mark_reg  input  4  destination register being marked.
REQ-008 rd_addr_a, rd_addr_b  input  4 each  decode read addresses.
REQ-009 rd_data_a, rd_data_b  output  16 each  read data, combinational.
REQ-010 stall  output  1  decode must hold; combinational.
REQ-011 z_flag  output  1  zero flag for conditional fetch.
REQ-012 redirect_valid  output  1  one-cycle pulse: a write to R15 committed.
REQ-013 redirect_pc  output  16  new PC; valid only while redirect_valid=1.
REQ-014 halted  output  1  sticky; set by a committed SYS.
REQ-015 retire_count  output  16  committed-instruction counter.
REQ-016 sb_overflow  output  1  sticky scoreboard-overflow error.

Function
REQ-017 A commit occurs on a clock edge when valid_in=1 and halted=0; otherwise ir_in/result are ignored.
REQ-018 A writing commit is any commit whose opcode is not SYS 10011, NOP 10100, STR 01111, or PRE 11xxx; it writes result to regfile[dest].
REQ-019 On every commit with cc=01 (S) and opcode not NOP/PRE, z_flag <= (result==0); all other commits leave z_flag unchanged.
REQ-020 A writing commit with dest=15 drives redirect_valid=1 and redirect_pc=result on the following cycle only; otherwise redirect_valid=0.
REQ-021 A SYS commit sets halted on that edge; later commits are ignored, marks are still tracked.
REQ-022 Each commit increments retire_count by 1, wrapping 0xFFFF->0x0000.
REQ-023 Scoreboard: one 2-bit busy count per register (0..3).
REQ-024 mark_valid increments busy[mark_reg]; a writing commit decrements busy[dest], floored at 0.
REQ-025 A mark and a writing commit to the same register on the same edge leave that count unchanged.
REQ-026 A mark to a register at count 3 without a same-edge commit leaves the count at 3 and sets sb_overflow.
REQ-027 Reads of register 0..15 return regfile contents (see REQ-031 for bypass).
REQ-028 stall = 1 when, for port a or b, busy[addr]!=0 and that port is not bypass-satisfied (REQ-031).
REQ-029 Writes commit at the clock edge; a read in the same cycle sees the pre-edge value unless bypassed.

Reset
REQ-030 While reset=1: all 16 registers 0, all busy counts 0, z_flag 0, halted 0, redirect_valid 0, redirect_pc 0, retire_count 0, sb_overflow 0; a commit or mark coincident with reset is discarded.

Configuration
REQ-031 With BYPASS_WRITEBACK_EN defined: when a writing commit is pending this cycle with dest==rd_addr_x and busy[dest]==1, rd_data_x=result and port x does not cause stall.
REQ-032 Without BYPASS_WRITEBACK_EN: rd_data_x always equals regfile[rd_addr_x], and any nonzero busy count on a read address asserts stall.

Verification
REQ-033 Reset, then mark R3; commit ADD dest=3 result=0x1234, read R3 next cycle -> rd_data_a=0x1234, busy[3]=0, stall=0.
REQ-034 Mark R5, same-cycle read R5 while committing dest=5 result=0x00AA -> with macro: rd_data=0x00AA, stall=0; without: stall=1.
REQ-035 Commit SUB cc=01 result=0 -> z_flag=1; then commit cc=01 result=0x0001 -> z_flag=0; commit cc=00 result=0 -> z_flag unchanged.
REQ-036 Commit MOV dest=15 result=0x0040 -> redirect_valid=1 for exactly one cycle, redirect_pc=0x0040, R15=0x0040.
REQ-037 Mark R2 four times with no commit -> busy[2]=3, sb_overflow=1; commit SYS then ADD dest=2 -> halted=1, R2 unchanged, retire_count=1.
REQ-038 Assert reset mid-sequence after 3 commits -> retire_count, registers, flags all 0 asynchronously before next edge.
